m4_ram_bridge: RTL and testbench
================================

// Module: m4_ram_bridge
// PURPOSE
//  Sits between regs_module and the shared 32-bit FPGA RAM. It also faces the M4 side.
//  - Converts the byte-wide data-provider (DP) port into 32-bit RAM accesses with byte selects.
//  - Exposes a Wishbone slave to the M4 for the command registers, the COMPLETE strobe and the 2 KiB RAM window.
//  - Arbitrates single-port RAM access between DP and M4. DP always wins.
// PARAMETERS
//  RAM_ADDR_WIDTH        11           DP byte address width (2 KiB buffer, 512 words)
//  COMPLETE_PULSE_WIDTH  20           cycles 'complete' stays high after an M4 write to COMPLETE
//  DEFAULT_READ_VALUE    32'hBADFABAC returned for M4 reads of unmapped addresses
// PORTS
//  clk_i        in   1    single clock for DP, M4 and RAM sides
//  nrst_i       in   1    reset, asynchronous, active-low
//  DP_addr      in   11   DP byte address
//  DP_data_wr   in   8    DP write byte
//  DP_wr_en     in   1    DP write strobe, one cycle per byte
//  DP_rd_en     in   1    DP read strobe, one cycle per byte
//  DP_data_rd   out  8    DP read byte, valid the cycle after DP_rd_en
//  op_type      in   4    command type from regs_module
//  locality     in   4    command locality from regs_module
//  buf_len      in   11   command buffer length from regs_module
//  exec         in   1    command pending
//  abort        in   1    command aborted by host
//  complete     out  1    completion pulse to regs_module
//  wb_adr_i     in   17   M4 byte offset from 0x40020000
//  wb_dat_i     in   32   M4 write data
//  wb_sel_i     in   4    M4 byte lanes
//  wb_we_i      in   1    M4 write
//  wb_cyc_i     in   1    Wishbone cycle
//  wb_stb_i     in   1    Wishbone strobe
//  wb_dat_o     out  32   M4 read data
//  wb_ack_o     out  1    M4 ack, single-cycle
//  RAM_A        out  9    RAM word address
//  RAM_WD       out  32   RAM write data
//  RAM_RD       in   32   RAM read data, one cycle after address (synchronous)
//  RAM_WE       out  1    RAM write enable
//  RAM_byte_sel out  4    RAM byte lane enables
// BEHAVIOUR
//  Reset values: complete=0, wb_ack_o=0, wb_dat_o=0, DP_data_rd=0, RAM_WE=0, RAM_byte_sel=0, RAM_A=0, FSM=IDLE, pulse counter=0.
//  DP path (combinational to RAM, no FSM):
//  - RAM_A=DP_addr[10:2].
//  - Write: RAM_WD={4{DP_data_wr}}, RAM_byte_sel=1<<DP_addr[1:0], RAM_WE=1.
//  - Read: DP_addr[1:0] is registered; the next cycle DP_data_rd=RAM_RD byte[idx]. Latency is 1.
//  - DP_wr_en and DP_rd_en together: the write wins and the read is ignored.
//  M4 register map (wb_adr_i):
//  - 0x00 STATUS RO {30'b0,abort,exec}
//  - 0x04 OP_TYPE RO {28'b0,op_type}
//  - 0x08 LOCALITY RO {28'b0,locality}
//  - 0x0C BUF_SIZE RO {21'b0,buf_len}
//  - 0x40 COMPLETE WO, any data; reads return 0
//  - 0x800-0xFFF RAM window, word index=wb_adr_i[10:2]
//  - Unmapped reads return DEFAULT_READ_VALUE. Unmapped writes are dropped.
//  - Every access is acked exactly once. wb_adr_i[1:0] are ignored.
//  M4 FSM states: IDLE, RAM_REQ, RAM_DATA, ACK.
//  - IDLE: on cyc&stb, non-RAM address -> latch read data / act on write -> ACK. RAM address -> RAM_REQ.
//  - RAM_REQ: if DP_wr_en|DP_rd_en this cycle, stay (DP priority). Otherwise drive RAM_A, and for writes RAM_WD=wb_dat_i, RAM_byte_sel=wb_sel_i, RAM_WE=wb_we_i.
//    - Write -> ACK.
//    - Read -> RAM_DATA.
//  - RAM_DATA: capture wb_dat_o=RAM_RD -> ACK. DP strobes in this cycle still own the RAM address bus.
//  - ACK: wb_ack_o=1 for one cycle -> IDLE. A new cyc&stb is not sampled until IDLE.
//  - cyc dropped before ack: FSM completes the RAM access, suppresses ack, returns to IDLE.
//  COMPLETE pulse:
//  - Write to 0x40 loads counter=COMPLETE_PULSE_WIDTH. complete=(counter!=0), registered, so it rises the cycle after ACK.
//  - Counter decrements to 0 and saturates.
//  - Re-write during a pulse reloads the counter, extending the pulse.
//  - abort=1 forces counter=0 and complete=0.
//  Reset mid-operation: FSM, counter and all outputs return to reset values immediately. A pending ack is lost.
// TESTING
//  - DP write 0xA5 @0x006 then DP read 0x006 -> RAM word 1 lane 2 written (byte_sel=4'b0100); DP_data_rd=0xA5 one cycle later.
//  - M4 read 0x00C with buf_len=0x123 -> wb_dat_o=0x00000123, ack 2 cycles after stb; read 0x010 -> 0xBADFABAC.
//  - M4 write 0xDEADBEEF sel=4'b0011 @0x804, then DP reads 0x004..0x007 -> EF,BE,old,old.
//  - M4 RAM read while DP strobes 3 consecutive cycles -> ack delayed by exactly 3 cycles, data correct, DP reads unaffected.
//  - M4 write 0x40 -> complete high 20 cycles. Rewrite at cycle 10 -> 30 total. abort mid-pulse -> complete=0 next cycle.
//  - nrst_i low during RAM_DATA -> no ack, wb_ack_o=0, complete=0, FSM IDLE; next M4 access completes normally.

Source files
------------

// File: rtl/m4_ram_bridge.sv
// m4_ram_bridge: shares one single-port 32-bit RAM between a byte-wide DP port and an M4 Wishbone slave
module m4_ram_bridge #(
   parameter int          RAM_ADDR_WIDTH       = 11,
   parameter int          COMPLETE_PULSE_WIDTH = 20,
   parameter logic [31:0] DEFAULT_READ_VALUE   = 32'hBADFABAC
) (
   input  logic                      clk_i,
   input  logic                      nrst_i,
   input  logic [RAM_ADDR_WIDTH-1:0] DP_addr,
   input  logic [7:0]                DP_data_wr,
   input  logic                      DP_wr_en,
   input  logic                      DP_rd_en,
   output logic [7:0]                DP_data_rd,
   input  logic [3:0]                op_type,
   input  logic [3:0]                locality,
   input  logic [10:0]               buf_len,
   input  logic                      exec,
   input  logic                      abort,
   output logic                      complete,
   input  logic [16:0]               wb_adr_i,
   input  logic [31:0]               wb_dat_i,
   input  logic [3:0]                wb_sel_i,
   input  logic                      wb_we_i,
   input  logic                      wb_cyc_i,
   input  logic                      wb_stb_i,
   output logic [31:0]               wb_dat_o,
   output logic                      wb_ack_o,
   output logic [RAM_ADDR_WIDTH-3:0] RAM_A,
   output logic [31:0]               RAM_WD,
   input  logic [31:0]               RAM_RD,
   output logic                      RAM_WE,
   output logic [3:0]                RAM_byte_sel
);
   localparam int AW = RAM_ADDR_WIDTH - 2;
   localparam int CW = $clog2(COMPLETE_PULSE_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RAM_REQ, RAM_DATA, ACK} state_t;

   state_t        state;
   logic [16:0]   word;
   logic          is_ram;
   logic          accept;
   logic          complete_wr;
   logic          dp_busy;
   logic          m4_drive;
   logic          rd_q;
   logic [1:0]    idx_q;
   logic [AW-1:0] adr_q;
   logic [31:0]   dat_q;
   logic [3:0]    sel_q;
   logic          we_q;
   logic          drop;
   logic [31:0]   reg_rd;
   logic [CW-1:0] cnt;

   // word offset of the M4 access; the byte bits fall off here
   assign word        = wb_adr_i >> 2;
   assign is_ram      = (word >> AW) == 17'd1;
   // a new request is taken only from IDLE and never while the previous ack is still visible
   assign accept      = state == IDLE && wb_cyc_i && wb_stb_i && !wb_ack_o;
   assign complete_wr = accept && wb_we_i && word == 17'h10;
   assign dp_busy     = DP_wr_en | DP_rd_en;
   assign m4_drive    = state == RAM_REQ && !dp_busy;
   assign DP_data_rd  = rd_q ? 8'(RAM_RD >> {idx_q, 3'b000}) : 8'h00;

   // RAM bus mux: any DP strobe owns the RAM, the M4 only gets it from RAM_REQ
   always_comb begin
      RAM_A        = dp_busy ? DP_addr[RAM_ADDR_WIDTH-1:2] : m4_drive ? adr_q : '0;
      RAM_WD       = DP_wr_en ? {4{DP_data_wr}} : m4_drive ? dat_q : 32'h0;
      RAM_byte_sel = DP_wr_en ? 4'b0001 << DP_addr[1:0] : (m4_drive && we_q) ? sel_q : 4'b0000;
      RAM_WE       = DP_wr_en | (m4_drive & we_q);
   end

   // register file read decode for the non-RAM part of the M4 map
   always_comb begin
      reg_rd = (word == 17'h0)  ? {30'b0, abort, exec} :
               (word == 17'h1)  ? {28'b0, op_type} :
               (word == 17'h2)  ? {28'b0, locality} :
               (word == 17'h3)  ? {21'b0, buf_len} :
               (word == 17'h10) ? 32'h0 : DEFAULT_READ_VALUE;
   end

   // DP read lane remembered for the cycle the synchronous RAM returns data; a write in the same cycle cancels the read
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         rd_q  <= 1'b0;
         idx_q <= 2'b00;
      end else begin
         rd_q  <= DP_rd_en & ~DP_wr_en;
         idx_q <= DP_addr[1:0];
      end
   end

   // M4 Wishbone FSM; request is latched on accept so an abandoned cycle still finishes its RAM access
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state    <= IDLE;
         wb_ack_o <= 1'b0;
         wb_dat_o <= 32'h0;
         adr_q    <= '0;
         dat_q    <= 32'h0;
         sel_q    <= 4'h0;
         we_q     <= 1'b0;
         drop     <= 1'b0;
      end else begin
         wb_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  adr_q <= word[AW-1:0];
                  dat_q <= wb_dat_i;
                  sel_q <= wb_sel_i;
                  we_q  <= wb_we_i;
                  drop  <= 1'b0;
                  if (!is_ram && !wb_we_i) wb_dat_o <= reg_rd;
                  state <= is_ram ? RAM_REQ : ACK;
               end
            end
            RAM_REQ: begin
               drop <= drop | ~wb_cyc_i;
               if (!dp_busy) state <= we_q ? ACK : RAM_DATA;
            end
            RAM_DATA: begin
               drop     <= drop | ~wb_cyc_i;
               wb_dat_o <= RAM_RD;
               state    <= ACK;
            end
            ACK: begin
               wb_ack_o <= wb_cyc_i & ~drop;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // completion pulse: reloadable down-counter, abort kills it at once
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         cnt      <= '0;
         complete <= 1'b0;
      end else if (abort) begin
         cnt      <= '0;
         complete <= 1'b0;
      end else begin
         cnt      <= complete_wr ? CW'(COMPLETE_PULSE_WIDTH) : (cnt != '0) ? cnt - CW'(1) : cnt;
         complete <= cnt != '0;
      end
   end
endmodule

// File: tb/tb_m4_ram_bridge.sv
// tb_m4_ram_bridge: directed tests of the DP path, M4 register/RAM access, arbitration, completion pulse and reset
module tb_m4_ram_bridge;
   logic        clk = 1'b0;
   logic        nrst_i;
   logic [10:0] DP_addr;
   logic [7:0]  DP_data_wr;
   logic        DP_wr_en;
   logic        DP_rd_en;
   logic [7:0]  DP_data_rd;
   logic [3:0]  op_type;
   logic [3:0]  locality;
   logic [10:0] buf_len;
   logic        exec;
   logic        abort;
   logic        complete;
   logic [16:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic [8:0]  RAM_A;
   logic [31:0] RAM_WD;
   logic [31:0] RAM_RD;
   logic        RAM_WE;
   logic [3:0]  RAM_byte_sel;

   int total = 0;
   int bad = 0;
   int hi_cnt = 0;
   logic hi_clr;

   always #5 clk = ~clk;

   m4_ram_bridge dut (
      .clk_i(clk), .nrst_i(nrst_i),
      .DP_addr(DP_addr), .DP_data_wr(DP_data_wr), .DP_wr_en(DP_wr_en), .DP_rd_en(DP_rd_en), .DP_data_rd(DP_data_rd),
      .op_type(op_type), .locality(locality), .buf_len(buf_len), .exec(exec), .abort(abort), .complete(complete),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
      .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .RAM_A(RAM_A), .RAM_WD(RAM_WD), .RAM_RD(RAM_RD), .RAM_WE(RAM_WE), .RAM_byte_sel(RAM_byte_sel)
   );

   // synchronous single-port RAM model with byte lanes, read-first
   logic [31:0] mem [512];
   logic [31:0] lane_m;
   assign lane_m = {{8{RAM_byte_sel[3]}}, {8{RAM_byte_sel[2]}}, {8{RAM_byte_sel[1]}}, {8{RAM_byte_sel[0]}}};
   always @(posedge clk) begin
      if (RAM_WE) mem[RAM_A] <= (RAM_WD & lane_m) | (mem[RAM_A] & ~lane_m);
      RAM_RD <= mem[RAM_A];
   end

   // number of cycles complete was high since the last clear
   always @(posedge clk) hi_cnt <= hi_clr ? 0 : hi_cnt + (complete ? 1 : 0);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dp_write(input logic [10:0] a, input logic [7:0] d);
      DP_addr = a; DP_data_wr = d; DP_wr_en = 1'b1;
      tick();
      DP_wr_en = 1'b0;
   endtask

   task automatic dp_read(input logic [10:0] a, output logic [7:0] d);
      DP_addr = a; DP_rd_en = 1'b1;
      tick();
      DP_rd_en = 1'b0;
      d = DP_data_rd;
   endtask

   // one Wishbone access; n = cycles from strobe to ack, -1 if no ack within the budget
   task automatic m4_access(input logic we, input logic [16:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] q, output int n);
      wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      n = 0;
      q = 32'h0;
      do begin
         tick();
         n++;
      end while (!wb_ack_o && n < 40);
      if (wb_ack_o) q = wb_dat_o; else n = -1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      total++; if (complete !== 1'b0) begin bad++; $display("FAIL reset_complete got=%b exp=0", complete); end
      total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", wb_ack_o); end
      total++; if (wb_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h exp=0", wb_dat_o); end
      total++; if (DP_data_rd !== 8'h0) begin bad++; $display("FAIL reset_dp_rd got=%h exp=0", DP_data_rd); end
      total++; if ({RAM_WE, RAM_byte_sel, RAM_A} !== 14'h0) begin bad++; $display("FAIL reset_ram got=%b/%b/%h exp=0/0/0", RAM_WE, RAM_byte_sel, RAM_A); end
      nrst_i = 1'b1;
      tick();
   endtask

   task automatic test_dp();
      logic [7:0] b;
      tick();
      DP_addr = 11'h006; DP_data_wr = 8'hA5; DP_wr_en = 1'b1;
      #1;
      total++;
      if ({RAM_WE, RAM_byte_sel, RAM_A, RAM_WD} !== {1'b1, 4'b0100, 9'd1, 32'hA5A5A5A5}) begin
         bad++; $display("FAIL dp_wr_bus got=%b/%b/%h/%h exp=1/0100/001/a5a5a5a5", RAM_WE, RAM_byte_sel, RAM_A, RAM_WD);
      end
      tick();
      DP_wr_en = 1'b0;
      dp_read(11'h006, b);
      total++; if (b !== 8'hA5) begin bad++; $display("FAIL dp_rd got=%h exp=a5", b); end
      DP_addr = 11'h006; DP_data_wr = 8'h3C; DP_wr_en = 1'b1; DP_rd_en = 1'b1;
      tick();
      DP_wr_en = 1'b0; DP_rd_en = 1'b0;
      total++; if (DP_data_rd !== 8'h00) begin bad++; $display("FAIL dp_collide_rd got=%h exp=00", DP_data_rd); end
      dp_read(11'h006, b);
      total++; if (b !== 8'h3C) begin bad++; $display("FAIL dp_collide_wr got=%h exp=3c", b); end
   endtask

   task automatic test_regs();
      logic [16:0] a [8] = '{17'h00C, 17'h010, 17'h000, 17'h004, 17'h008, 17'h040, 17'h00E, 17'h1000};
      logic [31:0] e [8] = '{32'h123, 32'hBADFABAC, 32'h1, 32'hA, 32'h3, 32'h0, 32'h123, 32'hBADFABAC};
      logic [31:0] q;
      int n;
      exec = 1'b1; op_type = 4'hA; locality = 4'h3; buf_len = 11'h123;
      for (int i = 0; i < 8; i++) begin
         tick();
         m4_access(1'b0, a[i], 32'h0, 4'hF, q, n);
         total++;
         if (q !== e[i] || n !== 2) begin
            bad++; $display("FAIL reg_read adr=%h got=%h/%0d exp=%h/2", a[i], q, n, e[i]);
         end
      end
      tick();
      total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL ack_single got=%b exp=0", wb_ack_o); end
   endtask

   task automatic test_ram_write();
      logic [7:0] e [4] = '{8'hEF, 8'hBE, 8'h22, 8'h11};
      logic [7:0] b;
      logic [31:0] q;
      int n;
      tick();
      dp_write(11'h004, 8'h44);
      dp_write(11'h005, 8'h33);
      dp_write(11'h006, 8'h22);
      dp_write(11'h007, 8'h11);
      tick();
      m4_access(1'b1, 17'h804, 32'hDEADBEEF, 4'b0011, q, n);
      total++; if (n !== 3) begin bad++; $display("FAIL ram_wr_lat got=%0d exp=3", n); end
      tick();
      for (int i = 0; i < 4; i++) begin
         dp_read(11'(4 + i), b);
         total++; if (b !== e[i]) begin bad++; $display("FAIL ram_wr_lane%0d got=%h exp=%h", i, b, e[i]); end
      end
      tick();
      m4_access(1'b0, 17'h804, 32'h0, 4'hF, q, n);
      total++; if (q !== 32'h1122BEEF || n !== 4) begin bad++; $display("FAIL ram_rd got=%h/%0d exp=1122beef/4", q, n); end
   endtask

   task automatic test_dp_priority();
      logic [7:0] b0, b1, b2;
      logic [31:0] q;
      int n;
      tick();
      fork
         m4_access(1'b0, 17'h806, 32'h0, 4'hF, q, n);
         begin
            tick();
            dp_read(11'h004, b0);
            dp_read(11'h005, b1);
            dp_read(11'h006, b2);
         end
      join
      total++; if (q !== 32'h1122BEEF || n !== 7) begin bad++; $display("FAIL prio_m4 got=%h/%0d exp=1122beef/7", q, n); end
      total++; if ({b0, b1, b2} !== 24'hEFBE22) begin bad++; $display("FAIL prio_dp got=%h exp=efbe22", {b0, b1, b2}); end
   endtask

   task automatic test_cyc_drop();
      logic [7:0] b;
      logic [31:0] q;
      int n;
      logic seen;
      tick();
      wb_adr_i = 17'h814; wb_dat_i = 32'hCAFEF00D; wb_sel_i = 4'hF; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      tick();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         tick();
         if (wb_ack_o) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL drop_ack got=%b exp=0", seen); end
      dp_read(11'h014, b);
      total++; if (b !== 8'h0D) begin bad++; $display("FAIL drop_wr_lo got=%h exp=0d", b); end
      dp_read(11'h017, b);
      total++; if (b !== 8'hCA) begin bad++; $display("FAIL drop_wr_hi got=%h exp=ca", b); end
      tick();
      m4_access(1'b0, 17'h814, 32'h0, 4'hF, q, n);
      total++; if (q !== 32'hCAFEF00D || n !== 4) begin bad++; $display("FAIL drop_next got=%h/%0d exp=cafef00d/4", q, n); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q1, q2, q3, qw;
      int n1, n2, n3, nw;
      tick();
      m4_access(1'b0, 17'h00C, 32'h0, 4'hF, q1, n1);
      m4_access(1'b0, 17'h814, 32'h0, 4'hF, q2, n2);
      m4_access(1'b1, 17'h818, 32'h12345678, 4'hF, qw, nw);
      m4_access(1'b0, 17'h818, 32'h0, 4'hF, q3, n3);
      total++; if (q1 !== 32'h123 || n1 < 0) begin bad++; $display("FAIL b2b_reg got=%h/%0d exp=00000123", q1, n1); end
      total++; if (q2 !== 32'hCAFEF00D || n2 < 0) begin bad++; $display("FAIL b2b_ram got=%h/%0d exp=cafef00d", q2, n2); end
      total++; if (q3 !== 32'h12345678 || n3 < 0 || nw < 0) begin bad++; $display("FAIL b2b_wr_rd got=%h/%0d/%0d exp=12345678", q3, nw, n3); end
   endtask

   task automatic test_complete();
      logic [31:0] q;
      int n;
      tick();
      hi_clr = 1'b1;
      tick();
      hi_clr = 1'b0;
      m4_access(1'b1, 17'h040, 32'h0, 4'hF, q, n);
      total++; if (n !== 2 || complete !== 1'b1) begin bad++; $display("FAIL cmp_rise got=%0d/%b exp=2/1", n, complete); end
      repeat (40) tick();
      total++; if (hi_cnt !== 20 || complete !== 1'b0) begin bad++; $display("FAIL cmp_width got=%0d/%b exp=20/0", hi_cnt, complete); end
      hi_clr = 1'b1;
      tick();
      hi_clr = 1'b0;
      m4_access(1'b1, 17'h040, 32'h0, 4'hF, q, n);
      repeat (8) tick();
      m4_access(1'b1, 17'h040, 32'h0, 4'hF, q, n);
      repeat (40) tick();
      total++; if (hi_cnt !== 30) begin bad++; $display("FAIL cmp_extend got=%0d exp=30", hi_cnt); end
   endtask

   task automatic test_abort();
      logic [31:0] q;
      int n;
      tick();
      m4_access(1'b1, 17'h040, 32'h0, 4'hF, q, n);
      repeat (5) tick();
      total++; if (complete !== 1'b1) begin bad++; $display("FAIL abort_pre got=%b exp=1", complete); end
      abort = 1'b1;
      tick();
      total++; if (complete !== 1'b0) begin bad++; $display("FAIL abort_kill got=%b exp=0", complete); end
      abort = 1'b0;
      repeat (3) tick();
      total++; if (complete !== 1'b0) begin bad++; $display("FAIL abort_stay got=%b exp=0", complete); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] q;
      int n;
      tick();
      m4_access(1'b1, 17'h040, 32'h0, 4'hF, q, n);
      tick();
      wb_adr_i = 17'h804; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      tick();
      tick();
      nrst_i = 1'b0;
      #1;
      total++; if ({wb_ack_o, complete} !== 2'b00 || wb_dat_o !== 32'h0) begin bad++; $display("FAIL rst_mid got=%b%b/%h exp=00/0", wb_ack_o, complete, wb_dat_o); end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      tick();
      total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL rst_mid_ack got=%b exp=0", wb_ack_o); end
      nrst_i = 1'b1;
      tick();
      m4_access(1'b0, 17'h804, 32'h0, 4'hF, q, n);
      total++; if (q !== 32'h1122BEEF || n !== 4 || complete !== 1'b0) begin bad++; $display("FAIL rst_mid_next got=%h/%0d/%b exp=1122beef/4/0", q, n, complete); end
   endtask

   initial begin
      nrst_i = 1'b0; hi_clr = 1'b1;
      DP_addr = '0; DP_data_wr = '0; DP_wr_en = 1'b0; DP_rd_en = 1'b0;
      op_type = '0; locality = '0; buf_len = '0; exec = 1'b0; abort = 1'b0;
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      test_reset();
      test_dp();
      test_regs();
      test_ram_write();
      test_dp_priority();
      test_cyc_drop();
      test_back_to_back();
      test_complete();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
